// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage instruction-memory, control and IF/ID bundle
interface fetch_stage_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0]      imem_rdata;
    logic                  stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0]      if_id_inst;
    logic [ADDR_WIDTH-1:0] if_id_pc;
    logic                  if_id_valid;
    logic                  halted;
    logic [31:0]           fetch_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output if_id_inst,
        output if_id_pc,
        output if_id_valid,
        output halted,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  if_id_inst,
        input  if_id_pc,
        input  if_id_valid,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, stall/redirect/halt control
module fetch_stage #(
    parameter int                     WIDTH      = 32,
    parameter int                     ADDR_WIDTH = 8,
    parameter int unsigned            RESET_PC   = 0,
    parameter logic [WIDTH-1:0]       HALT_INST  = {WIDTH{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]      inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic [31:0]           count_q, count_d;
    logic                  halted_q, halted_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        count_d = count_q;

        if (bus.redirect_valid) begin
            // Redirect squashes IF/ID but leaves its payload in place; consumers key on valid.
            pc_d    = bus.redirect_pc;
            valid_d = 1'b0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    if (!bus.stall) begin
                        if (bus.imem_rdata == HALT_INST) begin
                            valid_d = 1'b0;
                            state_d = S_HALT;
                        end else begin
                            inst_d  = bus.imem_rdata;
                            ipc_d   = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + ADDR_WIDTH'(1);
                            count_d = count_q + 32'd1;
                        end
                    end
                end
                S_HALT: begin
                    if (!bus.stall) begin
                        valid_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_INIT;
            inst_q   <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            count_q  <= 32'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_inst  = inst_q;
    assign bus.if_id_pc    = ipc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule
